// File: rtl/phy_clk_pkg.sv
// Mode codes, state encoding and divider constants shared by the
// PHY clock-mode controller and its clock-enable generator.
package phy_clk_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_WIFI   = 3'd1,
        MODE_FOUR_G = 3'd2,
        MODE_TWO_G  = 3'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    localparam int unsigned QUIET_CYCLES_DEFAULT = 16;
    localparam logic [10:0] FRAME_LEN = 11'd1280;

    localparam logic [10:0] DIV_100M = 11'd2;
    localparam logic [10:0] DIV_50M  = 11'd4;
    localparam logic [10:0] DIV_20M  = 11'd10;
    localparam logic [10:0] DIV_312K = 11'd640;
    localparam logic [10:0] DIV_156K = 11'd1280;

    // Bit order of the enable vector: {156K, 312K, 20M, 50M, 100M}
    function automatic logic [4:0] ce_mask(input mode_t mode);
        case (mode)
            MODE_WIFI:   return 5'b00111;
            MODE_FOUR_G: return 5'b00110;
            MODE_TWO_G:  return 5'b11000;
            default:     return 5'b00000;
        endcase
    endfunction

    function automatic logic mode_valid(input logic [2:0] code);
        return code <= 3'd3;
    endfunction

endpackage

// File: rtl/phy_clk_mode_ctrl_if.sv
// Mode-change request handshake between a requester and the controller.
interface phy_clk_mode_ctrl_if;

    logic       mode_req_valid;
    logic [2:0] mode_req;
    logic       mode_req_ready;

    modport master (
        output mode_req_valid,
        output mode_req,
        input  mode_req_ready
    );

    modport slave (
        input  mode_req_valid,
        input  mode_req,
        output mode_req_ready
    );

endinterface

// File: rtl/clk_ce_gen.sv
// Frame divider counter and registered, mode-masked clock-enable strobes.
module clk_ce_gen
    import phy_clk_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        count_en_i,
    input  logic        active_d_i,
    input  mode_t       mode_d_i,
    output logic [10:0] div_cnt_o,
    output logic [4:0]  ce_o
);

    logic [10:0] cnt_q, cnt_d;
    logic [4:0]  ce_q, ce_d;

    // Strobes are decoded from the next count so the registered enable lines
    // up with the cycle in which div_cnt holds the matching value.
    always_comb begin
        cnt_d = 11'd0;
        if (count_en_i && active_d_i) begin
            cnt_d = (cnt_q == FRAME_LEN - 11'd1) ? 11'd0 : cnt_q + 11'd1;
        end

        ce_d = 5'd0;
        if (active_d_i) begin
            ce_d[0] = (cnt_d % DIV_100M) == (DIV_100M - 11'd1);
            ce_d[1] = (cnt_d % DIV_50M)  == (DIV_50M  - 11'd1);
            ce_d[2] = (cnt_d % DIV_20M)  == (DIV_20M  - 11'd1);
            ce_d[3] = (cnt_d % DIV_312K) == (DIV_312K - 11'd1);
            ce_d[4] = (cnt_d % DIV_156K) == (DIV_156K - 11'd1);
            ce_d    = ce_d & ce_mask(mode_d_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 11'd0;
            ce_q  <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign div_cnt_o = cnt_q;
    assign ce_o      = ce_q;

endmodule

// File: rtl/phy_clk_mode_ctrl.sv
// PHY clock-mode controller: accepts mode requests, drains the current frame,
// holds all enables quiet, then switches the enable mask to the new mode.
module phy_clk_mode_ctrl
    import phy_clk_pkg::*;
#(
    parameter int unsigned QUIET_CYCLES = QUIET_CYCLES_DEFAULT
) (
    input  logic                clk_200_MHz,
    input  logic                reset,
    phy_clk_mode_ctrl_if.slave  req_if,
    output logic [2:0]          mode_cur,
    output logic                switching,
    output logic                mode_err,
    output logic                ce_100_MHz,
    output logic                ce_50_MHz,
    output logic                ce_20_MHz,
    output logic                ce_312_KHz,
    output logic                ce_156_KHz
);

    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

    state_t      state_q, state_d;
    mode_t       mode_q, mode_d;
    mode_t       pending_q, pending_d;
    logic [7:0]  quiet_q, quiet_d;
    logic        err_q, err_d;
    logic        ready_q, ready_d;
    logic        switching_q, switching_d;
    logic        count_en, active_d;
    logic        accept;
    logic [10:0] div_cnt;
    logic [4:0]  ce;

    assign accept = req_if.mode_req_valid & ready_q;

    always_ff @(posedge clk_200_MHz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_OFF;
            mode_q      <= MODE_OFF;
            pending_q   <= MODE_OFF;
            quiet_q     <= 8'd0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            switching_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            pending_q   <= pending_d;
            quiet_q     <= quiet_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
            switching_q <= switching_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        pending_d = pending_q;
        quiet_d   = quiet_q;
        err_d     = 1'b0;
        case (state_q)
            ST_OFF, ST_RUN: begin
                if (accept) begin
                    if (!mode_valid(req_if.mode_req)) begin
                        err_d = 1'b1;
                    end else if (req_if.mode_req != mode_q) begin
                        pending_d = mode_t'(req_if.mode_req);
                        quiet_d   = 8'd0;
                        state_d   = (state_q == ST_RUN) ? ST_DRAIN : ST_QUIET;
                    end
                end
            end
            ST_DRAIN: begin
                if (div_cnt == FRAME_LEN - 11'd1) begin
                    state_d = ST_QUIET;
                    quiet_d = 8'd0;
                end
            end
            ST_QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    mode_d  = pending_q;
                    quiet_d = 8'd0;
                    state_d = (pending_q == MODE_OFF) ? ST_OFF : ST_RUN;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Status flags are registered from the next state so they track state_q.
    always_comb begin
        ready_d     = (state_d == ST_OFF)   || (state_d == ST_RUN);
        switching_d = (state_d == ST_DRAIN) || (state_d == ST_QUIET);
        count_en    = (state_q == ST_RUN)   || (state_q == ST_DRAIN);
        active_d    = (state_d == ST_RUN)   || (state_d == ST_DRAIN);
    end

    clk_ce_gen u_ce_gen (
        .clk_i      (clk_200_MHz),
        .rst_ni     (reset),
        .count_en_i (count_en),
        .active_d_i (active_d),
        .mode_d_i   (mode_d),
        .div_cnt_o  (div_cnt),
        .ce_o       (ce)
    );

    assign req_if.mode_req_ready = ready_q;
    assign mode_cur   = mode_q;
    assign switching  = switching_q;
    assign mode_err   = err_q;
    assign ce_100_MHz = ce[0];
    assign ce_50_MHz  = ce[1];
    assign ce_20_MHz  = ce[2];
    assign ce_312_KHz = ce[3];
    assign ce_156_KHz = ce[4];

endmodule

// File: tb/tb_phy_clk_mode_ctrl.sv
// Scoreboard bench for phy_clk_mode_ctrl: expected per-cycle output vectors
// are queued when a request is driven and compared at each falling edge.
module tb_phy_clk_mode_ctrl;

    logic       clk  = 1'b0;
    logic       rstN = 1'b1;
    logic       ce100, ce50, ce20, ce312, ce156;
    logic       switching, modeErr;
    logic [2:0] modeCur;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          benchCnt    = 0;
    logic [10:0] sb[$];

    phy_clk_mode_ctrl_if reqIf();

    phy_clk_mode_ctrl #(.QUIET_CYCLES(16)) dut (
        .clk_200_MHz (clk),
        .reset       (rstN),
        .req_if      (reqIf),
        .mode_cur    (modeCur),
        .switching   (switching),
        .mode_err    (modeErr),
        .ce_100_MHz  (ce100),
        .ce_50_MHz   (ce50),
        .ce_20_MHz   (ce20),
        .ce_312_KHz  (ce312),
        .ce_156_KHz  (ce156)
    );

    always #5 clk = ~clk;

    // Expected vector {ready, switching, mode_err, mode_cur, ce156..ce100}.
    function automatic logic [10:0] mk(input logic rdy, input logic sw, input logic err,
                                       input logic [2:0] mode, input logic act, input int cnt);
        logic [4:0] ce;
        ce = 5'd0;
        if (act) begin
            if (mode == 3'd1) begin
                ce[0] = (cnt % 2) == 1;
                ce[1] = (cnt % 4) == 3;
                ce[2] = (cnt % 10) == 9;
            end else if (mode == 3'd2) begin
                ce[1] = (cnt % 4) == 3;
                ce[2] = (cnt % 10) == 9;
            end else if (mode == 3'd3) begin
                ce[3] = (cnt % 640) == 639;
                ce[4] = (cnt % 1280) == 1279;
            end
        end
        return {rdy, sw, err, mode, ce};
    endfunction

    function automatic logic [10:0] observe();
        return {reqIf.mode_req_ready, switching, modeErr, modeCur, ce156, ce312, ce20, ce50, ce100};
    endfunction

    task automatic push_run(input logic [2:0] mode, input int n, input logic firstErr);
        for (int i = 0; i < n; i++) begin
            sb.push_back(mk(1'b1, 1'b0, (i == 0) && firstErr, mode, 1'b1, benchCnt));
            benchCnt = (benchCnt + 1) % 1280;
        end
    endtask

    task automatic push_drain(input logic [2:0] mode);
        while (benchCnt < 1280) begin
            sb.push_back(mk(1'b0, 1'b1, 1'b0, mode, 1'b1, benchCnt));
            benchCnt++;
        end
        benchCnt = 0;
    endtask

    task automatic push_quiet(input logic [2:0] mode, input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(1'b0, 1'b1, 1'b0, mode, 1'b0, 0));
        benchCnt = 0;
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) sb.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0));
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        benchCnt = 0;
    endtask

    task automatic drive_req(input logic [2:0] code);
        reqIf.mode_req_valid = 1'b1;
        reqIf.mode_req       = code;
    endtask

    task automatic test_reset();
        logic [10:0] obsV;
        logic [10:0] expV;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        obsV = observe();
        testsRun++;
        if (obsV !== 11'd0) begin
            testsFailed++;
            $display("[TB] FAIL resetHold: got %b, expected %b", obsV, 11'd0);
        end
        rstN = 1'b1;
        @(negedge clk);
        obsV = observe();
        expV = mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        testsRun++;
        if (obsV !== expV) begin
            testsFailed++;
            $display("[TB] FAIL resetRelease: got %b, expected %b", obsV, expV);
        end
        benchCnt = 0;
    endtask

    task automatic test_off_to_wifi();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        drive_req(3'd1);
        push_quiet(3'd0, 16);
        push_run(3'd1, 40, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL offToWifi cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            reqIf.mode_req_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic test_invalid_code();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        drive_req(3'd5);
        push_run(3'd1, 5, 1'b1);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL invalidCode cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            reqIf.mode_req_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic test_same_mode();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        drive_req(3'd1);
        push_run(3'd1, 5, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL sameMode cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            reqIf.mode_req_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic test_wifi_to_two_g();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        push_run(3'd1, ((500 - benchCnt + 1280) % 1280) + 1, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL wifiTo500 cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            idx++;
        end
        idx = 0;
        drive_req(3'd3);
        push_drain(3'd1);
        push_quiet(3'd1, 16);
        push_run(3'd3, 1300, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL wifiToTwoG cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            reqIf.mode_req_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic test_held_during_quiet();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        do_reset();
        drive_req(3'd1);
        push_quiet(3'd0, 16);
        push_run(3'd1, 1, 1'b0);
        push_drain(3'd1);
        push_quiet(3'd1, 16);
        push_run(3'd2, 30, 1'b0);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL heldInQuiet cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            if (idx == 0) reqIf.mode_req = 3'd2;
            if (idx == 17) reqIf.mode_req_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic test_reset_in_quiet();
        logic [10:0] obsV;
        logic [10:0] expV;
        int idx = 0;
        do_reset();
        drive_req(3'd3);
        push_quiet(3'd0, 5);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL quietBeforeReset cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            reqIf.mode_req_valid = 1'b0;
            idx++;
        end
        rstN = 1'b0;
        #1;
        obsV = observe();
        testsRun++;
        if (obsV !== 11'd0) begin
            testsFailed++;
            $display("[TB] FAIL resetInQuietAsync: got %b, expected %b", obsV, 11'd0);
        end
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        idx = 0;
        push_idle(40);
        while (sb.size() != 0) begin
            @(negedge clk);
            expV = sb.pop_front();
            obsV = observe();
            testsRun++;
            if (obsV !== expV) begin
                testsFailed++;
                $display("[TB] FAIL afterQuietReset cycle %0d: got %b, expected %b", idx, obsV, expV);
            end
            idx++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reqIf.mode_req_valid = 1'b0;
        reqIf.mode_req       = 3'd0;
        #1;
        test_reset();
        test_off_to_wifi();
        test_invalid_code();
        test_same_mode();
        test_wifi_to_two_g();
        test_held_during_quiet();
        test_reset_in_quiet();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
